if_id_skid_stage: RTL and testbench

Parametrised fetch→decode pipeline stage replacing the plain stall/flush IF/ID register. Holds PC and instruction payload in a two-entry skid buffer with valid/ready handshakes on both sides. This gives full throughput with a registered `in_ready`, so no combinational ready path runs back into fetch. A flush discards all held entries and the beat accepted in the same cycle. Sits between the fetch unit and the decode stage.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/if_id_skid_stage_sat_counter.sv | 23 ++
 rtl/if_id_skid_stage.sv | 157 +++++++++++++++
 tb/tb_if_id_skid_stage.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the fetch/decode pipeline stages.
// Provides the skid-buffer occupancy encoding, the statistics counter width
// and the default bubble instruction.
package pipe_pkg;

  // Occupancy of a two-entry skid buffer
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  localparam int unsigned STAT_W = 16;

  // All-zero bubble; individual stages may override with an ISA-specific NOP
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

endpackage : pipe_pkg

// File: rtl/if_id_skid_stage_sat_counter.sv
// sat_counter: width-parametrised event counter that sticks at all-ones.
// Used by if_id_skid_stage for its optional statistics.
module sat_counter
  import pipe_pkg::*;
#(
  parameter int unsigned W = STAT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Increment on request, hold once every bit is set
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule : sat_counter

// File: rtl/if_id_skid_stage.sv
// if_id_skid_stage: fetch -> decode register built as a two-entry skid buffer.
// in_ready is registered, so fetch never sees a combinational path from
// decode's out_ready. A flush empties the buffer and drops the beat accepted
// in the same cycle; a pop in that cycle still completes.
// Optional statistics ports are enabled by defining IF_ID_SKID_STATS_EN.
//
// state     | meaning
// ----------+---------------------------------------------------------
// OCC_EMPTY | nothing held, outputs show PC=0 / NOP_INSTR
// OCC_ONE   | main holds the beat on out_*, skid unused
// OCC_TWO   | main on out_*, skid holds the next beat, in_ready=0
module if_id_skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned          PC_W      = 32,
  parameter int unsigned          INSTR_W   = 32,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = INSTR_W'(NOP_INSTR_DEFAULT)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr
`ifdef IF_ID_SKID_STATS_EN
  ,
  output logic [STAT_W-1:0]  flush_count,
  output logic [STAT_W-1:0]  bubble_count
`endif
);

  occ_e               state_q;
  occ_e               state_nxt;
  logic               in_ready_q;
  logic [PC_W-1:0]    main_pc_q;
  logic [INSTR_W-1:0] main_instr_q;
  logic [PC_W-1:0]    skid_pc_q;
  logic [INSTR_W-1:0] skid_instr_q;
  logic               accept;
  logic               pop;

  assign out_valid = (state_q != OCC_EMPTY);
  assign in_ready  = in_ready_q;
  assign out_pc    = main_pc_q;
  assign out_instr = main_instr_q;

  assign accept = in_valid & in_ready_q;
  assign pop    = out_valid & out_ready;

  // Occupancy transition; flush overrides everything and empties the buffer
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      OCC_EMPTY: begin
        if (accept) state_nxt = OCC_ONE;
      end
      OCC_ONE: begin
        if (accept && !pop)      state_nxt = OCC_TWO;
        else if (!accept && pop) state_nxt = OCC_EMPTY;
      end
      OCC_TWO: begin
        if (pop) state_nxt = OCC_ONE;
      end
      default: state_nxt = OCC_EMPTY;
    endcase
    if (flush) state_nxt = OCC_EMPTY;
  end

  // Occupancy and registered ready; ready depends only on the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= OCC_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_nxt;
      in_ready_q <= (state_nxt != OCC_TWO);
    end
  end

  // Payload movement; anything heading to EMPTY is scrubbed to a NOP bubble
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_pc_q    <= '0;
      main_instr_q <= NOP_INSTR;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
    end else if (state_nxt == OCC_EMPTY) begin
      main_pc_q    <= '0;
      main_instr_q <= NOP_INSTR;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
    end else begin
      unique case (state_q)
        OCC_EMPTY: begin
          if (accept) begin
            main_pc_q    <= in_pc;
            main_instr_q <= in_instr;
          end
        end
        OCC_ONE: begin
          if (accept && pop) begin
            main_pc_q    <= in_pc;
            main_instr_q <= in_instr;
          end else if (accept) begin
            skid_pc_q    <= in_pc;
            skid_instr_q <= in_instr;
          end
        end
        OCC_TWO: begin
          // Without a pop the whole buffer holds still
          if (pop) begin
            main_pc_q    <= skid_pc_q;
            main_instr_q <= skid_instr_q;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
          end
        end
        default: begin
          main_pc_q    <= '0;
          main_instr_q <= NOP_INSTR;
        end
      endcase
    end
  end

`ifdef IF_ID_SKID_STATS_EN
  logic flush_hit;
  logic bubble_hit;

  // A flush counts only when it actually kills something: the beat accepted
  // this cycle, or a held beat that is not being consumed by decode.
  assign flush_hit  = flush & (accept
                               | (state_q == OCC_TWO)
                               | ((state_q == OCC_ONE) & ~out_ready));
  assign bubble_hit = out_ready & ~out_valid;

  sat_counter #(.W(STAT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_hit),
    .count (flush_count)
  );

  sat_counter #(.W(STAT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (bubble_hit),
    .count (bubble_count)
  );
`endif

endmodule : if_id_skid_stage

// File: tb/tb_if_id_skid_stage.sv
// Directed bench for if_id_skid_stage: a vector table for streaming, stall,
// and flush cases, followed by hand-written async-reset and counter runs.
module tb_if_id_skid_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
`ifdef IF_ID_SKID_STATS_EN
  logic [15:0] flush_count;
  logic [15:0] bubble_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  if_id_skid_stage #(
    .PC_W      (32),
    .INSTR_W   (32),
    .NOP_INSTR (NOP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr)
`ifdef IF_ID_SKID_STATS_EN
    ,
    .flush_count  (flush_count),
    .bubble_count (bubble_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        fl;
    logic        ordy;
    logic        ev;
    logic        er;
    logic [31:0] epc;
    logic [15:0] efc;
  } vec_t;

  vec_t vecs[19];

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'hC000_0000 | pc;
  endfunction

  function automatic vec_t mk(input logic v, input logic [31:0] pc, input logic fl,
                              input logic ordy, input logic ev, input logic er,
                              input logic [31:0] epc, input logic [15:0] efc);
    vec_t r;
    r.v = v; r.pc = pc; r.fl = fl; r.ordy = ordy;
    r.ev = ev; r.er = er; r.epc = epc; r.efc = efc;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic fl, input logic ordy);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = instr_of(pc);
    flush     = fl;
    out_ready = ordy;
  endtask

  initial begin
    //             v  pc  fl or | ev er epc fc
    vecs[0]  = mk(1,  4, 0, 1,  1, 1,  4, 0);  // stream
    vecs[1]  = mk(1,  8, 0, 1,  1, 1,  8, 0);
    vecs[2]  = mk(1, 12, 0, 1,  1, 1, 12, 0);
    vecs[3]  = mk(0,  0, 0, 1,  0, 1,  0, 0);  // drain to empty
    vecs[4]  = mk(1,  4, 0, 1,  1, 1,  4, 0);  // stall: fill
    vecs[5]  = mk(1,  8, 0, 0,  1, 0,  4, 0);  // skid absorbs 8
    vecs[6]  = mk(1, 12, 0, 0,  1, 0,  4, 0);  // full, 12 refused, hold
    vecs[7]  = mk(0,  0, 0, 1,  1, 1,  8, 0);  // pop 4, 8 moves up
    vecs[8]  = mk(0,  0, 0, 1,  0, 1,  0, 0);  // pop 8
    vecs[9]  = mk(1,  4, 0, 0,  1, 1,  4, 0);  // fill to TWO again
    vecs[10] = mk(1,  8, 0, 0,  1, 0,  4, 0);
    vecs[11] = mk(1, 16, 1, 0,  0, 1,  0, 1);  // flush in TWO
    vecs[12] = mk(0,  0, 0, 1,  0, 1,  0, 1);  // 16 never shows up
    vecs[13] = mk(1,  4, 0, 0,  1, 1,  4, 1);
    vecs[14] = mk(1, 24, 1, 1,  0, 1,  0, 2);  // flush with pop of 4 + accept 24
    vecs[15] = mk(0,  0, 0, 1,  0, 1,  0, 2);
    vecs[16] = mk(1, 28, 1, 1,  0, 1,  0, 3);  // flush of an accept into EMPTY
    vecs[17] = mk(0,  0, 0, 1,  0, 1,  0, 3);
    vecs[18] = mk(0,  0, 1, 1,  0, 1,  0, 3);  // flush with nothing to kill

    reset = 1'b0;
    drive(0, 0, 0, 0);
    #12;
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset in_ready",  {31'd0, in_ready},  32'd1);
    check("reset out_pc",    out_pc,    32'd0);
    check("reset out_instr", out_instr, NOP);
`ifdef IF_ID_SKID_STATS_EN
    check("reset flush_count",  {16'd0, flush_count},  32'd0);
    check("reset bubble_count", {16'd0, bubble_count}, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].pc, vecs[i].fl, vecs[i].ordy);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].ev});
      check($sformatf("vec%0d in_ready", i),  {31'd0, in_ready},  {31'd0, vecs[i].er});
      check($sformatf("vec%0d out_pc", i),    out_pc, vecs[i].epc);
      check($sformatf("vec%0d out_instr", i), out_instr,
            vecs[i].ev ? instr_of(vecs[i].epc) : NOP);
`ifdef IF_ID_SKID_STATS_EN
      check($sformatf("vec%0d flush_count", i), {16'd0, flush_count}, {16'd0, vecs[i].efc});
`endif
    end

    // Async reset while holding two entries
    @(negedge clk);
    drive(1, 40, 0, 0);
    @(negedge clk);
    drive(1, 44, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0);
    check("two-entry in_ready", {31'd0, in_ready}, 32'd0);
    #2;
    reset = 1'b0;
    #1;
    check("async rst out_valid", {31'd0, out_valid}, 32'd0);
    check("async rst in_ready",  {31'd0, in_ready},  32'd1);
    check("async rst out_pc",    out_pc,    32'd0);
    check("async rst out_instr", out_instr, NOP);
`ifdef IF_ID_SKID_STATS_EN
    check("async rst flush_count", {16'd0, flush_count}, 32'd0);
`endif
    repeat (2) @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("post-rst%0d out_valid", k), {31'd0, out_valid}, 32'd0);
      check($sformatf("post-rst%0d out_pc", k),    out_pc, 32'd0);
    end

`ifdef IF_ID_SKID_STATS_EN
    // Idle with decode ready: every cycle is a bubble, counter must pin at max
    @(negedge clk);
    drive(0, 0, 0, 1);
    repeat (70000) @(posedge clk);
    #1;
    check("bubble_count saturated", {16'd0, bubble_count}, 32'h0000_FFFF);
    check("flush_count idle",       {16'd0, flush_count},  32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_if_id_skid_stage
